// File: rtl/uart_tx_fifo_if.sv
// Byte-write and status bundle for the buffered UART transmitter.
// The master drives writes and overrun clears; the slave (transmitter) returns FIFO/line status.
interface uart_tx_fifo_if #(
  parameter int LEVEL_W = 3
) ();
  logic               wr_en;
  logic [7:0]         wr_data;
  logic               clr_overrun;
  logic               full;
  logic               empty;
  logic [LEVEL_W-1:0] level;
  logic               busy;
  logic               overrun;
  logic               uart_tx;

  modport master (
    output wr_en, wr_data, clr_overrun,
    input  full, empty, level, busy, overrun, uart_tx
  );

  modport slave (
    input  wr_en, wr_data, clr_overrun,
    output full, empty, level, busy, overrun, uart_tx
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: power-of-two byte FIFO feeding a start/data/parity/stop framer.
// Frames are issued back-to-back whenever the FIFO still holds data at the end of a stop bit.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0
) (
  input  logic         clk,
  input  logic         reset,
  uart_tx_fifo_if.slave bus
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = PTR_W + 1;
  localparam int BAUD_W  = $clog2(CLK_DIV);
  localparam int BIT_W   = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]   DATA_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]   STOP_LAST  = BIT_W'(STOP_BITS - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(FIFO_DEPTH);
  localparam logic               ODD_PAR    = (PARITY == 2);
  localparam logic               HAS_PAR    = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [LEVEL_W-1:0]   level_q;
  logic [LEVEL_W-1:0]   level_d;
  logic                 full_q;
  logic                 empty_q;
  logic                 overrun_q;
  logic                 overrun_d;
  logic                 wr_accept;
  logic                 wr_drop;
  logic                 pop;

  // Framer state
  state_e               state_q;
  state_e               state_d;
  logic [BAUD_W-1:0]    baud_q;
  logic [BAUD_W-1:0]    baud_d;
  logic [BIT_W-1:0]     bit_q;
  logic [BIT_W-1:0]     bit_d;
  logic [DATA_BITS-1:0] data_q;
  logic [DATA_BITS-1:0] data_d;
  logic                 tx_q;
  logic                 tx_d;
  logic                 baud_last;

  // Acceptance looks only at the registered full flag, so a same-cycle pop never rescues a write.
  assign wr_accept = bus.wr_en && !full_q;
  assign wr_drop   = bus.wr_en &&  full_q;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= bus.wr_data[DATA_BITS-1:0];
    end
  end

  always_comb begin
    level_d = level_q;
    case ({wr_accept, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (wr_drop) begin
      overrun_d = 1'b1;
    end else if (bus.clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q   <= level_d;
      full_q    <= (level_d == LEVEL_FULL);
      empty_q   <= (level_d == '0);
      overrun_q <= overrun_d;
    end
  end

  // Framer: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  assign baud_last = (baud_q == BAUD_LAST);

  // Framer: next state; the baud counter restarts on every state or bit change
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!empty_q) begin
          pop     = 1'b1;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = HAS_PAR ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (!empty_q) begin
              pop     = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered read of the FIFO head straight into the frame register
  always_comb begin
    data_d = data_q;
    if (pop) begin
      data_d = mem_q[rd_ptr_q];
    end
  end

  // Framer: outputs, computed from next state so uart_tx leaves a flop
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = data_d[bit_d];
      S_PAR:   tx_d = (^data_d) ^ ODD_PAR;
      default: tx_d = 1'b1;
    endcase
  end

  // Upper wr_data bits are intentionally ignored when DATA_BITS < 8
  logic unused_wr_data;
  assign unused_wr_data = ^bus.wr_data;

  assign bus.full    = full_q;
  assign bus.empty   = empty_q;
  assign bus.level   = level_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.overrun = overrun_q;
  assign bus.uart_tx = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: three framer configurations (8N1, 7E2, 5O2) driven in lockstep and
// compared every clock against a frame-level model of queue occupancy and line waveform.
module tb_uart_tx_fifo;

  localparam int IDLE_FS = -100000;

  logic clk;
  logic reset;

  logic       wr_en_v   [3];
  logic [7:0] wr_data_v [3];
  logic       clr_v     [3];

  logic       tx_o   [3];
  logic       busy_o [3];
  logic       empty_o[3];
  logic       full_o [3];
  logic       ovr_o  [3];
  logic [3:0] level_o[3];

  uart_tx_fifo_if #(.LEVEL_W(3)) if_a ();
  uart_tx_fifo_if #(.LEVEL_W(3)) if_b ();
  uart_tx_fifo_if #(.LEVEL_W(2)) if_c ();

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY(0))
    dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  uart_tx_fifo #(.CLK_DIV(2), .DATA_BITS(7), .FIFO_DEPTH(4), .STOP_BITS(2), .PARITY(1))
    dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
  uart_tx_fifo #(.CLK_DIV(3), .DATA_BITS(5), .FIFO_DEPTH(2), .STOP_BITS(2), .PARITY(2))
    dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

  assign if_a.wr_en = wr_en_v[0];  assign if_a.wr_data = wr_data_v[0];  assign if_a.clr_overrun = clr_v[0];
  assign if_b.wr_en = wr_en_v[1];  assign if_b.wr_data = wr_data_v[1];  assign if_b.clr_overrun = clr_v[1];
  assign if_c.wr_en = wr_en_v[2];  assign if_c.wr_data = wr_data_v[2];  assign if_c.clr_overrun = clr_v[2];

  assign tx_o[0] = if_a.uart_tx;  assign busy_o[0] = if_a.busy;  assign empty_o[0] = if_a.empty;
  assign full_o[0] = if_a.full;   assign ovr_o[0] = if_a.overrun; assign level_o[0] = {1'b0, if_a.level};
  assign tx_o[1] = if_b.uart_tx;  assign busy_o[1] = if_b.busy;  assign empty_o[1] = if_b.empty;
  assign full_o[1] = if_b.full;   assign ovr_o[1] = if_b.overrun; assign level_o[1] = {1'b0, if_b.level};
  assign tx_o[2] = if_c.uart_tx;  assign busy_o[2] = if_c.busy;  assign empty_o[2] = if_c.empty;
  assign full_o[2] = if_c.full;   assign ovr_o[2] = if_c.overrun; assign level_o[2] = {2'b00, if_c.level};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert;
  int n_fail;
  int edge_no;

  // Frame-level model: queued bytes, byte on the line and the edge its start bit began
  logic [7:0] m_buf [3][8];
  int         m_cnt [3];
  int         m_fs  [3];
  logic [7:0] m_fb  [3];
  logic       m_ovr [3];

  function automatic int p_cdiv(input int k);
    case (k) 0: return 4; 1: return 2; default: return 3; endcase
  endfunction
  function automatic int p_db(input int k);
    case (k) 0: return 8; 1: return 7; default: return 5; endcase
  endfunction
  function automatic int p_par(input int k);
    case (k) 0: return 0; 1: return 1; default: return 2; endcase
  endfunction
  function automatic int p_stop(input int k);
    case (k) 0: return 1; default: return 2; endcase
  endfunction
  function automatic int p_depth(input int k);
    case (k) 2: return 2; default: return 4; endcase
  endfunction

  function automatic int fl(input int k);
    return (1 + p_db(k) + ((p_par(k) != 0) ? 1 : 0) + p_stop(k)) * p_cdiv(k);
  endfunction

  // Bit j of the frame carrying byte b: start, data LSB first, optional parity, stops
  function automatic logic frame_bit(input int k, input logic [7:0] b, input int j);
    logic [7:0] mask;
    mask = 8'((1 << p_db(k)) - 1);
    if (j == 0) return 1'b0;
    if (j <= p_db(k)) return b[j-1];
    if (p_par(k) != 0 && j == p_db(k) + 1) return (^(b & mask)) ^ (p_par(k) == 2);
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d edge %0d: observed %0h expected %0h", tag, k, edge_no, obs, exp);
    end
  endtask

  task automatic model_edge(input int k);
    logic full_b;
    if (reset) begin
      m_cnt[k] = 0;
      m_fs[k]  = IDLE_FS;
      m_ovr[k] = 1'b0;
    end else begin
      full_b = (m_cnt[k] == p_depth(k));
      if (m_cnt[k] > 0 && edge_no >= m_fs[k] + fl(k)) begin
        m_fb[k] = m_buf[k][0];
        for (int i = 0; i < 7; i++) m_buf[k][i] = m_buf[k][i+1];
        m_cnt[k]--;
        m_fs[k] = edge_no;
      end
      if (wr_en_v[k] && !full_b) begin
        m_buf[k][m_cnt[k]] = wr_data_v[k];
        m_cnt[k]++;
      end
      if (wr_en_v[k] && full_b) m_ovr[k] = 1'b1;
      else if (clr_v[k])        m_ovr[k] = 1'b0;
    end
  endtask

  task automatic check_dut(input int k);
    int   rel;
    logic act;
    logic exp_tx;
    rel    = edge_no - m_fs[k];
    act    = (rel >= 0) && (rel < fl(k));
    exp_tx = act ? frame_bit(k, m_fb[k], rel / p_cdiv(k)) : 1'b1;
    chk("uart_tx", k, 32'(tx_o[k]),    32'(exp_tx));
    chk("busy",    k, 32'(busy_o[k]),  32'(act));
    chk("level",   k, 32'(level_o[k]), 32'(m_cnt[k]));
    chk("empty",   k, 32'(empty_o[k]), 32'(m_cnt[k] == 0));
    chk("full",    k, 32'(full_o[k]),  32'(m_cnt[k] == p_depth(k)));
    chk("overrun", k, 32'(ovr_o[k]),   32'(m_ovr[k]));
  endtask

  task automatic cycle();
    @(posedge clk);
    edge_no++;
    for (int k = 0; k < 3; k++) model_edge(k);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_dut(k);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_en_v[k] = 1'b0;
      clr_v[k]   = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic write_all(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    wr_en_v[0] = 1'b1; wr_data_v[0] = b0;
    wr_en_v[1] = 1'b1; wr_data_v[1] = b1;
    wr_en_v[2] = 1'b1; wr_data_v[2] = b2;
  endtask

  initial begin
    int busy_cnt;
    n_assert = 0;
    n_fail   = 0;
    edge_no  = 0;
    for (int k = 0; k < 3; k++) begin
      wr_en_v[k] = 1'b0; wr_data_v[k] = 8'h00; clr_v[k] = 1'b0;
      m_cnt[k] = 0; m_fs[k] = IDLE_FS; m_fb[k] = 8'h00; m_ovr[k] = 1'b0;
      for (int i = 0; i < 8; i++) m_buf[k][i] = 8'h00;
    end

    // Reset state
    reset = 1'b1; cycle();
    reset = 1'b1; cycle();
    $display("reset: tx=%b busy=%b empty=%b level=%0d", tx_o[0], busy_o[0], empty_o[0], level_o[0]);

    // Single frames: 0xA5 on 8N1, 0x83 on 7E2, 0xE0 on 5O2
    write_all(8'hA5, 8'h83, 8'hE0);
    busy_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      cycle();
      if (busy_o[0]) busy_cnt++;
    end
    chk("busy_len_8n1", 0, 32'(busy_cnt), 32'd40);
    $display("single frame: 8N1 busy for %0d clocks", busy_cnt);

    // Six back-to-back writes: fill, overrun, gapless frames
    for (int i = 0; i < 6; i++) begin
      write_all(8'($urandom), 8'($urandom), 8'($urandom));
      cycle();
    end
    chk("burst_overrun", 0, 32'(ovr_o[0]), 32'd1);
    $display("burst: level=%0d full=%b overrun=%b", level_o[0], full_o[0], ovr_o[0]);

    // Dropped write, clear and pop all land on the same edge
    while (edge_no + 1 < m_fs[0] + fl(0)) cycle();
    chk("prec_full_before", 0, 32'(full_o[0]), 32'd1);
    wr_en_v[0] = 1'b1; wr_data_v[0] = 8'h3C; clr_v[0] = 1'b1;
    cycle();
    chk("prec_overrun", 0, 32'(ovr_o[0]), 32'd1);
    chk("prec_level",   0, 32'(level_o[0]), 32'd3);
    clr_v[0] = 1'b1;
    cycle();
    chk("clr_overrun", 0, 32'(ovr_o[0]), 32'd0);
    $display("precedence: overrun cleared to %b, level=%0d", ovr_o[0], level_o[0]);
    run(200);

    // Randomized writes and clears on all three framers
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 3; k++) begin
        wr_en_v[k]   = ($urandom_range(0, 2) == 0);
        wr_data_v[k] = 8'($urandom);
        clr_v[k]     = ($urandom_range(0, 15) == 0);
      end
      cycle();
    end
    $display("random phase done at edge %0d", edge_no);
    run(220);

    // Reset mid-frame with bytes queued, then a clean frame
    for (int i = 0; i < 3; i++) begin
      write_all(8'($urandom), 8'($urandom), 8'($urandom));
      cycle();
    end
    run(10);
    reset = 1'b1;
    cycle();
    chk("rst_tx",    0, 32'(tx_o[0]),    32'd1);
    chk("rst_busy",  0, 32'(busy_o[0]),  32'd0);
    chk("rst_level", 0, 32'(level_o[0]), 32'd0);
    chk("rst_empty", 0, 32'(empty_o[0]), 32'd1);
    $display("mid-frame reset: tx=%b busy=%b level=%0d", tx_o[0], busy_o[0], level_o[0]);
    write_all(8'h55, 8'h55, 8'h55);
    run(50);
    $display("post-reset 0x55 frame checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
